// File: rtl/alu_seq.sv
// alu_seq: registered integer ALU with valid/ready handshakes on both sides.
// Single-cycle ops produce a result one clock after acceptance; MUL and DIVU
// iterate one bit per clock and present their result ALU_WIDTH+1 clocks after
// acceptance. One request is in flight at a time.
module alu_seq #(
  parameter int ALU_WIDTH      = 32,
  parameter int ALU_FUNC_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_WIDTH-1:0]      a,
  input  logic [ALU_WIDTH-1:0]      b,
  input  logic                      ci,
  input  logic [ALU_FUNC_WIDTH-1:0] f,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ALU_WIDTH-1:0]      s,
  output logic [ALU_WIDTH-1:0]      s_hi,
  output logic                      co,
  output logic                      err
);

  localparam int CNT_W = $clog2(ALU_WIDTH) + 1;

  localparam logic [ALU_FUNC_WIDTH-1:0] F_ADD  = ALU_FUNC_WIDTH'(0);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_SUB  = ALU_FUNC_WIDTH'(1);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_AND  = ALU_FUNC_WIDTH'(2);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_OR   = ALU_FUNC_WIDTH'(3);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_XOR  = ALU_FUNC_WIDTH'(4);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_MAX  = ALU_FUNC_WIDTH'(5);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_MIN  = ALU_FUNC_WIDTH'(6);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_ONE  = ALU_FUNC_WIDTH'(7);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_MUL  = ALU_FUNC_WIDTH'(8);
  localparam logic [ALU_FUNC_WIDTH-1:0] F_DIVU = ALU_FUNC_WIDTH'(9);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Iteration datapath: acc_hi/acc_lo hold {partial product, multiplier}
  // for MUL and {remainder, quotient} for DIVU; op_b is the multiplicand or
  // divisor captured at acceptance.
  logic [ALU_WIDTH-1:0] op_b;
  logic [ALU_WIDTH-1:0] acc_hi;
  logic [ALU_WIDTH-1:0] acc_lo;
  logic                 op_mul;
  logic [CNT_W-1:0]     cnt;

  logic iter_req;
  logic last_step;

  // Single-cycle result computed straight from the request inputs.
  logic [ALU_WIDTH:0]   sum_add;
  logic [ALU_WIDTH:0]   sum_sub;
  logic [ALU_WIDTH-1:0] sc_s;
  logic [ALU_WIDTH-1:0] sc_hi;
  logic                 sc_co;
  logic                 sc_err;

  // One iteration step of each algorithm.
  logic [ALU_WIDTH:0]   mul_sum;
  logic [ALU_WIDTH:0]   div_sh;
  logic [ALU_WIDTH:0]   div_diff;
  logic [ALU_WIDTH-1:0] step_hi;
  logic [ALU_WIDTH-1:0] step_lo;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Divide by zero completes immediately as an error; MUL by zero iterates.
  assign iter_req  = (f == F_MUL) || ((f == F_DIVU) && (b != '0));
  assign last_step = (state == BUSY) && (cnt == CNT_W'(ALU_WIDTH - 1));

  assign sum_add = {1'b0, a} + {1'b0, b}  + {{ALU_WIDTH{1'b0}}, ci};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{ALU_WIDTH{1'b0}}, ci};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaulting every always_comb output first guarantees no latch is
    // inferred on paths that do not assign it.
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = iter_req ? BUSY : DONE;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle function decode; also covers DIVU by zero and illegal codes.
  always_comb begin
    sc_s   = '0;
    sc_hi  = '0;
    sc_co  = 1'b0;
    sc_err = 1'b0;
    case (f)
      F_ADD:  {sc_co, sc_s} = sum_add;
      F_SUB:  {sc_co, sc_s} = sum_sub;
      F_AND:  sc_s = a & b;
      F_OR:   sc_s = a | b;
      F_XOR:  sc_s = a ^ b;
      F_MAX:  sc_s = (a >= b) ? a : b;
      F_MIN:  sc_s = (a <= b) ? a : b;
      F_ONE:  sc_s = ALU_WIDTH'(1);
      F_MUL:  sc_s = '0;
      F_DIVU: begin
        // Only reached with b == 0; b != 0 goes through the iterative path.
        sc_s   = '1;
        sc_hi  = a;
        sc_err = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  // Shift-add multiply step and restoring divide step.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : {(ALU_WIDTH + 1){1'b0}});
    div_sh   = {acc_hi, acc_lo[ALU_WIDTH-1]};
    div_diff = div_sh - {1'b0, op_b};
    if (op_mul) begin
      step_hi = mul_sum[ALU_WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[ALU_WIDTH-1:1]};
    end else if (div_sh >= {1'b0, op_b}) begin
      step_hi = div_diff[ALU_WIDTH-1:0];
      step_lo = {acc_lo[ALU_WIDTH-2:0], 1'b1};
    end else begin
      step_hi = div_sh[ALU_WIDTH-1:0];
      step_lo = {acc_lo[ALU_WIDTH-2:0], 1'b0};
    end
  end

  // Operand capture, iteration and result registers; outputs only load on
  // the transition into DONE and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_b   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      op_mul <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      s_hi   <= '0;
      co     <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (iter_req) begin
              op_b   <= b;
              acc_hi <= '0;
              acc_lo <= a;
              op_mul <= (f == F_MUL);
              cnt    <= '0;
            end else begin
              s    <= sc_s;
              s_hi <= sc_hi;
              co   <= sc_co;
              err  <= sc_err;
            end
          end
        end
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            s    <= step_lo;
            s_hi <= step_hi;
            co   <= 1'b0;
            err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed checks of alu_seq at ALU_WIDTH=8 with hand-computed
// expected values.
module tb_alu_seq;

  localparam int W  = 8;
  localparam int FW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ci;
  logic [FW-1:0] f;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic [W-1:0]  s_hi;
  logic          co;
  logic          err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  alu_seq #(.ALU_WIDTH(W), .ALU_FUNC_WIDTH(FW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .f(f),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .s_hi(s_hi), .co(co), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request and leave the bench in the cycle after acceptance.
  task automatic issue(input logic [FW-1:0] fv, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic civ);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step(1);
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL issue_timeout: in_ready=%b want 1 within 50 cycles", in_ready);
    end
    f = fv; a = av; b = bv; ci = civ;
    in_valid = 1'b1;
    step(1);
    in_valid = 1'b0;
  endtask

  // Complete the output handshake; bench is then in the IDLE cycle.
  task automatic retire();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({in_ready, out_valid, co, err} !== 4'b1000 || s !== 8'h00 || s_hi !== 8'h00)
      $display("FAIL reset_state: rdy=%b vld=%b co=%b err=%b s=%h s_hi=%h want 1 0 0 0 00 00",
               in_ready, out_valid, co, err, s, s_hi);
    else pass_cnt++;
  endtask

  task automatic test_add();
    issue(5'd0, 8'h01, 8'h02, 1'b1);
    total_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL add_latency: vld=%b rdy=%b want 1 0", out_valid, in_ready);
    else pass_cnt++;
    total_cnt++;
    if (s !== 8'h04 || co !== 1'b0 || err !== 1'b0 || s_hi !== 8'h00)
      $display("FAIL add_1_2_1: s=%h co=%b err=%b s_hi=%h want 04 0 0 00", s, co, err, s_hi);
    else pass_cnt++;
    retire();
    issue(5'd0, 8'hFF, 8'h01, 1'b0);
    total_cnt++;
    if (s !== 8'h00 || co !== 1'b1)
      $display("FAIL add_carry: s=%h co=%b want 00 1", s, co);
    else pass_cnt++;
    retire();
  endtask

  task automatic test_logic();
    logic [FW-1:0] fv  [8] = '{5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,  5'd20};
    logic [W-1:0]  av  [8] = '{8'h05, 8'hC3, 8'hC3, 8'hC3, 8'h02, 8'h80, 8'h55, 8'h12};
    logic [W-1:0]  bv  [8] = '{8'h07, 8'h5A, 8'h5A, 8'h5A, 8'h02, 8'h7F, 8'hAA, 8'h34};
    logic [W-1:0]  exs [8] = '{8'hFE, 8'h42, 8'hDB, 8'h99, 8'h02, 8'h7F, 8'h01, 8'h00};
    logic          exe [8] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    for (int i = 0; i < 8; i++) begin
      issue(fv[i], av[i], bv[i], 1'b1);
      total_cnt++;
      if (out_valid !== 1'b1 || s !== exs[i] || err !== exe[i] || co !== 1'b0 || s_hi !== 8'h00)
        $display("FAIL logic_f%0d: vld=%b s=%h err=%b co=%b s_hi=%h want 1 %h %b 0 00",
                 fv[i], out_valid, s, err, co, s_hi, exs[i], exe[i]);
      else pass_cnt++;
      retire();
    end
  endtask

  // Iterative op: in_ready/out_valid low for cycles 1..8, result at cycle 9.
  task automatic run_iter(input string name, input logic [FW-1:0] fv,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exs, input logic [W-1:0] exh);
    logic bad;
    issue(fv, av, bv, 1'b0);
    // Offer a competing request throughout BUSY; it must be ignored.
    f = 5'd0; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    bad = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      step(1);
    end
    in_valid = 1'b0;
    total_cnt++;
    if (bad) $display("FAIL %s_busy: handshake not low for 8 cycles (bad=%b want 0)", name, bad);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b1 || s !== exs || s_hi !== exh || err !== 1'b0 || co !== 1'b0)
      $display("FAIL %s_result: vld=%b s=%h s_hi=%h err=%b co=%b want 1 %h %h 0 0",
               name, out_valid, s, s_hi, err, co, exs, exh);
    else pass_cnt++;
    retire();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL %s_idle: rdy=%b vld=%b want 1 0", name, in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_mul();
    run_iter("mul_ff_ff", 5'd8, 8'hFF, 8'hFF, 8'h01, 8'hFE);
    run_iter("mul_0d_0b", 5'd8, 8'h0D, 8'h0B, 8'h8F, 8'h00);
    run_iter("mul_by0",   5'd8, 8'hA5, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_divu();
    run_iter("div_64_07", 5'd9, 8'h64, 8'h07, 8'h0E, 8'h02);
    run_iter("div_ff_10", 5'd9, 8'hFF, 8'h10, 8'h0F, 8'h0F);
    issue(5'd9, 8'h33, 8'h00, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || s !== 8'hFF || s_hi !== 8'h33 || err !== 1'b1)
      $display("FAIL div_by0: vld=%b s=%h s_hi=%h err=%b want 1 ff 33 1", out_valid, s, s_hi, err);
    else pass_cnt++;
    retire();
  endtask

  task automatic test_backpressure();
    logic bad;
    issue(5'd0, 8'h10, 8'h20, 1'b0);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || s !== 8'h30 || in_ready !== 1'b0) bad = 1'b1;
      step(1);
    end
    total_cnt++;
    if (bad) $display("FAIL bp_hold: output not held (bad=%b want 0)", bad);
    else pass_cnt++;
    retire();
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || s !== 8'h30)
      $display("FAIL bp_release: rdy=%b vld=%b s=%h want 1 0 30", in_ready, out_valid, s);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Continuous request and consumer: one op per 2 cycles, no bypass.
    f = 5'd4; a = 8'h0F; b = 8'h3C; ci = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step(1);
    total_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || s !== 8'h33)
      $display("FAIL b2b_first: vld=%b rdy=%b s=%h want 1 0 33", out_valid, in_ready, s);
    else pass_cnt++;
    a = 8'hF0;
    step(1);
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_gap: vld=%b rdy=%b want 0 1", out_valid, in_ready);
    else pass_cnt++;
    step(1);
    in_valid = 1'b0; out_ready = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b1 || s !== 8'hCC)
      $display("FAIL b2b_second: vld=%b s=%h want 1 cc", out_valid, s);
    else pass_cnt++;
    retire();
  endtask

  task automatic test_reset_mid_mul();
    issue(5'd8, 8'hFF, 8'hFF, 1'b0);
    step(3);
    total_cnt++;
    if (in_ready !== 1'b0)
      $display("FAIL rst_mid_busy: rdy=%b want 0", in_ready);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || s !== 8'h00 || in_ready !== 1'b1 || s_hi !== 8'h00)
      $display("FAIL rst_mid_clear: vld=%b s=%h rdy=%b s_hi=%h want 0 00 1 00",
               out_valid, s, in_ready, s_hi);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    step(1);
    issue(5'd0, 8'h03, 8'h04, 1'b0);
    total_cnt++;
    if (out_valid !== 1'b1 || s !== 8'h07 || co !== 1'b0)
      $display("FAIL rst_after_add: vld=%b s=%h co=%b want 1 07 0", out_valid, s, co);
    else pass_cnt++;
    retire();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; f = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1);
    test_add();
    test_logic();
    test_mul();
    test_divu();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
